// File: rtl/write_buffer_wt.sv
// Posted write buffer between a write-through cache and main memory.
// Stores are queued in a small circular FIFO and drained one at a time over
// a req/ack handshake. Repeated stores to a queued address are coalesced, and
// miss-fill reads are forwarded from the newest buffered copy.
module write_buffer_wt #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_hit,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_data,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_t;

    // Entry storage and FIFO bookkeeping.
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    state_t            state_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;

    logic              accept;
    logic              pop;
    logic              coal_hit;
    logic [PTR_W-1:0]  coal_idx;
    logic              alloc;
    logic [PTR_W-1:0]  fwd_idx;

    // Status outputs come only from registered state.
    assign wr_ready = (count_q != CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign mem_req  = (state_q == ST_REQ);
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;

    assign accept = wr_en && wr_ready;
    assign pop    = (state_q == ST_REQ) && mem_ack;
    assign alloc  = accept && !coal_hit;

    // Coalesce target: a valid entry other than the head. Whenever the buffer
    // is non-empty the head is either in flight or being latched this edge,
    // so it is never rewritten.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == wr_addr) && (PTR_W'(i) != head_q)) begin
                coal_hit = 1'b1;
                coal_idx = PTR_W'(i);
            end
        end
    end

    // Forwarding: walk entries oldest to newest so the newest match wins.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        fwd_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PTR_W'(k);
            if (valid_q[fwd_idx] && (addr_q[fwd_idx] == rd_addr)) begin
                rd_hit  = 1'b1;
                rd_data = data_q[fwd_idx];
            end
        end
    end

    // Next-state for pointers and occupancy; pop and allocate may coincide.
    always_comb begin
        head_d  = pop   ? head_q + PTR_W'(1) : head_q;
        tail_d  = alloc ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
    end

    // Control state, valid bits and the drain FSM with its registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
            end
            if (alloc) begin
                valid_q[tail_q] <= 1'b1;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            case (state_q)
                ST_IDLE: begin
                    if (count_q != '0) begin
                        mem_addr_q <= addr_q[head_q];
                        mem_data_q <= data_q[head_q];
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Entry payload writes: new allocation at tail or coalesce in place.
    always_ff @(posedge clk) begin
        // NOTE: the payload arrays are deliberately not reset; the valid bits
        // decide whether an entry is meaningful, so stale contents are harmless.
        if (accept) begin
            if (coal_hit) begin
                data_q[coal_idx] <= wr_data;
            end else begin
                addr_q[tail_q] <= wr_addr;
                data_q[tail_q] <= wr_data;
            end
        end
    end

endmodule

// File: doc/write_buffer_wt.md
# write_buffer_wt

Posted write buffer between the write-through direct-mapped cache and main memory. It absorbs every cache store (address plus word) into a small FIFO and drains entries to memory one at a time over a req/ack handshake, so the cache never waits on memory for a write. It coalesces repeated stores to the same address and forwards buffered data to cache miss reads, so a miss never returns stale memory contents.

## Interface
- DEPTH, 4, number of buffer entries (power of two, ≥2)
- ADDR_W, 10, address width (matches the cache's 10-bit address)
- DATA_W, 32, data word width
- clk  in  1  single clock, rising-edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  cache store request
- wr_addr  in  ADDR_W  store address
- wr_data  in  DATA_W  store data
- wr_ready  out  1  = !full; cache must hold the store while low
- rd_addr  in  ADDR_W  cache miss-fill lookup address
- rd_hit  out  1  combinational: rd_addr matches a valid entry
- rd_data  out  DATA_W  combinational: data of newest matching entry, 0 if no hit
- mem_req  out  1  drain request to main memory
- mem_addr  out  ADDR_W  drain address, stable while mem_req
- mem_data  out  DATA_W  drain data, stable while mem_req
- mem_ack  in  1  memory accepted the write; one-cycle pulse
- count  out  $clog2(DEPTH)+1  valid entries
- empty  out  1  count == 0

## Operation
- Storage: circular FIFO with head/tail pointers that wrap modulo DEPTH, a valid bit per entry, and a count register.
- Store accepted at a rising edge iff wr_en && wr_ready; wr_en while full is ignored, and the cache holds the store until wr_ready rises.
- Coalescing: if wr_addr matches a valid entry that is not the in-flight head, overwrite that entry's data. No allocation; count unchanged.
- If wr_addr matches only the in-flight head, allocate a new tail entry. The in-flight data is never modified.
- Otherwise write at tail, advance tail, count+1.
- Drain FSM, states IDLE and REQ:
  - IDLE: if count>0, latch head addr/data into mem_addr/mem_data, go to REQ.
  - REQ: mem_req=1, mem_addr/mem_data held. On mem_ack: invalidate head, advance head, count−1, go to IDLE.
  - mem_ack outside REQ is ignored.
- Simultaneous pop and allocate in one cycle: count unchanged, both pointers advance.
- Full and mem_ack in the same cycle: the store is still refused, because wr_ready is derived from registered count. It is accepted the next cycle.
- Forwarding: compare rd_addr against all valid entries, including the in-flight head. When there are two matches (head plus a newer tail entry), the newer entry wins.
- Reset (any cycle, including mid-handshake): all entries invalid, head=tail=0, count=0, state IDLE.
  - Outputs after reset: mem_req=0, mem_addr=0, mem_data=0, wr_ready=1, empty=1, rd_hit=0, rd_data=0.
  - Discarded writes are lost.
  - A mem_ack arriving after reset is ignored.

## Timing
- A store accepted at edge E0 is visible to rd_hit/count right after E0.
- With the FSM idle, mem_req rises after edge E1, so an empty buffer has 1 cycle of store-to-request latency.
- mem_ack sampled high at edge Ek: the pop occurs at Ek, and mem_req is low for at least the cycle after Ek. There is a minimum of one idle cycle between consecutive requests.
- Drain throughput: at most one entry per 2 cycles with a zero-wait memory (ack in the first REQ cycle).
- wr_ready, empty and count are registered-state-derived, with no combinational path from wr_en or mem_ack.
- rd_hit/rd_data are purely combinational from rd_addr and current entries, with no path from wr_en.

## Test plan
- **Reset and single drain:** reset 2 cycles, then store 0x000←0x000000FF.
  - Edge after the store: count=1, rd_hit=1 for rd_addr 0x000, rd_data=0xFF.
  - Next cycle: mem_req=1, mem_addr=0x000, mem_data=0xFF.
  - ack → count=0, empty=1, mem_req=0.
- **Fill and backpressure:** hold mem_ack=0 and store 0x004,0x008,0x00C,0x010,0x014 on consecutive cycles.
  - Required: first four accepted, wr_ready=0, count=4, the fifth held.
  - One ack → fifth accepted the cycle after wr_ready returns to 1.
  - Drain order in mem_addr: 0x004,0x008,0x00C,0x010,0x014.
- **Coalescing:** mem_ack=0, store 0x200←1, 0x300←2, 0x300←3.
  - Required: 0x200 goes in flight (mem_req=1); 0x300←3 coalesces into the queued 0x300 entry, so count=2.
  - rd_addr 0x300 → rd_data=3.
  - Drain sends (0x200,1) then (0x300,3).
- **In-flight no-coalesce:** 0x200←1 in flight with mem_ack=0, then store 0x200←5.
  - Required: count=2, mem_data stays 1, rd_data(0x200)=5.
  - After ack, the second request is (0x200,5).
- **Wrap and simultaneous pop/push:** run 10 stores interleaved with acks so that an accept and an ack share an edge.
  - Required: count unchanged on that edge, pointers wrap past DEPTH−1.
  - Every address reaches mem_addr exactly once, in order.
- **Reset mid-handshake:** 3 entries queued, mem_req=1; assert reset one cycle, then ack.
  - Required: count=0, mem_req=0, rd_hit=0 after reset; the late ack causes no pop or underflow.
